// File: rtl/sram_fifo_pkg.sv
// Shared defaults and helpers for the SRAM-backed FWFT FIFO controller.
// The optional overflow flag is enabled with FIFO_CTRL_ERR_FLAG_EN.
package sram_fifo_pkg;

    localparam int DATA_WIDTH_DEF  = 16;
    localparam int ADDR_WIDTH_DEF  = 7;
    localparam int DEPTH_DEF       = 128;

    // level spans SRAM words plus one in-flight read plus two skid entries
    localparam int LEVEL_EXTRA     = 2;
    localparam int LEVEL_WIDTH_DEF = ADDR_WIDTH_DEF + LEVEL_EXTRA;

    // Pointer advance with wrap at DEPTH-1; DEPTH need not be a power of two.
    function automatic logic [31:0] ptr_next(input logic [31:0] p, input int depth);
        return (p == 32'(depth - 1)) ? 32'd0 : p + 32'd1;
    endfunction

endpackage

// File: rtl/sram_fifo_ctrl_skid.sv
// Two-entry output skid: absorbs the SRAM read latency so the head word
// is presented combinationally and one pop per cycle is sustained.
module fifo_out_skid #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  pop,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic [1:0]            cnt
);

    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else if (flush) begin
            cnt  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else begin
            unique case ({load, pop})
                2'b10: begin
                    if (cnt == 2'd0) head <= load_data;
                    else             tail <= load_data;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    // with one entry the incoming word becomes the new head directly
                    if (cnt == 2'd1) begin
                        head <= load_data;
                    end else begin
                        head <= tail;
                        tail <= load_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid = (cnt != 2'd0);
    assign data  = head;

endmodule

// File: rtl/sram_fifo_ctrl.sv
// First-word-fall-through FIFO controller sequencing an external single-clock SRAM.
// Define FIFO_CTRL_ERR_FLAG_EN to add the sticky overflow flag and saturating counter.
module sram_fifo_ctrl
    import sram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_WIDTH-1:0]             in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic [ADDR_WIDTH+LEVEL_EXTRA-1:0] level,
    output logic                              sram_wr_en,
    output logic [ADDR_WIDTH-1:0]             sram_wr_ptr,
    output logic [DATA_WIDTH-1:0]             sram_data_in,
    output logic                              sram_rd_en,
    output logic [ADDR_WIDTH-1:0]             sram_rd_ptr,
    input  logic [DATA_WIDTH-1:0]             sram_data_out
`ifdef FIFO_CTRL_ERR_FLAG_EN
    ,
    output logic                              err_ovf,
    output logic [15:0]                       err_ovf_cnt
`endif
);

    localparam int LW = ADDR_WIDTH + LEVEL_EXTRA;
    localparam int CW = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         mem_cnt;
    logic                  inflight;
    logic [1:0]            skid_cnt;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic [2:0]            held_out;

    // Handshake: a word moves on a side only in a cycle where that side's
    // valid and ready are both high at the rising edge; flush cancels both.
    assign in_ready = (mem_cnt < CW'(DEPTH));
    assign push     = in_valid && in_ready && !flush;
    assign pop      = out_valid && out_ready && !flush;

    // Prefetch only while the skid, counting the read already in flight, has room.
    assign held_out = 3'(skid_cnt) + 3'(inflight);
    assign issue    = (mem_cnt != '0) && (held_out < (3'd2 + 3'(pop))) && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            inflight <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            inflight <= 1'b0;
        end else begin
            if (push)  wr_ptr <= ADDR_WIDTH'(ptr_next(32'(wr_ptr), DEPTH));
            if (issue) rd_ptr <= ADDR_WIDTH'(ptr_next(32'(rd_ptr), DEPTH));
            unique case ({push, issue})
                2'b10:   mem_cnt <= mem_cnt + CW'(1);
                2'b01:   mem_cnt <= mem_cnt - CW'(1);
                default: ;
            endcase
            inflight <= issue;
        end
    end

    fifo_out_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .load      (inflight),
        .load_data (sram_data_out),
        .pop       (pop),
        .valid     (out_valid),
        .data      (out_data),
        .cnt       (skid_cnt)
    );

    assign level        = LW'(mem_cnt) + LW'(inflight) + LW'(skid_cnt);
    assign sram_wr_en   = push;
    assign sram_wr_ptr  = wr_ptr;
    assign sram_data_in = in_data;
    assign sram_rd_en   = issue;
    assign sram_rd_ptr  = rd_ptr;

`ifdef FIFO_CTRL_ERR_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_ovf     <= 1'b0;
            err_ovf_cnt <= '0;
        end else if (flush) begin
            err_ovf     <= 1'b0;
            err_ovf_cnt <= '0;
        end else if (in_valid && !in_ready) begin
            err_ovf <= 1'b1;
            if (err_ovf_cnt != 16'hffff) err_ovf_cnt <= err_ovf_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Bench for sram_fifo_ctrl: directed steps plus randomized traffic checked
// against a word-queue model; an SRAM behavioural model sits beside the DUT.
module tb_sram_fifo_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 7;
    localparam int DEPTH = 128;
    localparam int LW    = AW + 2;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [LW-1:0] level;
    logic          sram_wr_en;
    logic [AW-1:0] sram_wr_ptr;
    logic [DW-1:0] sram_data_in;
    logic          sram_rd_en;
    logic [AW-1:0] sram_rd_ptr;
    logic [DW-1:0] sram_data_out;
`ifdef FIFO_CTRL_ERR_FLAG_EN
    logic          err_ovf;
    logic [15:0]   err_ovf_cnt;
`endif

    sram_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .level         (level),
        .sram_wr_en    (sram_wr_en),
        .sram_wr_ptr   (sram_wr_ptr),
        .sram_data_in  (sram_data_in),
        .sram_rd_en    (sram_rd_en),
        .sram_rd_ptr   (sram_rd_ptr),
        .sram_data_out (sram_data_out)
`ifdef FIFO_CTRL_ERR_FLAG_EN
        ,
        .err_ovf       (err_ovf),
        .err_ovf_cnt   (err_ovf_cnt)
`endif
    );

    // clock / reset / SRAM environment
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] sram_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (sram_wr_en) sram_mem[sram_wr_ptr] <= sram_data_in;
        if (sram_rd_en) sram_data_out <= sram_mem[sram_rd_ptr];
    end

    // scoreboard state
    logic [DW-1:0] exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    logic          stalled;
    logic [DW-1:0] stall_data;
    logic          last_push;
    int            n_acc;
    int            n_pop;
    logic [AW-1:0] last_wr;
    logic [AW-1:0] last_rd;
    logic          wr_wrap;
    logic          rd_wrap;
    logic [DW-1:0] next_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        exp_q.delete();
        stalled = 1'b0;
        n_acc   = 0;
        n_pop   = 0;
        wr_wrap = 1'b0;
        rd_wrap = 1'b0;
        last_wr = '0;
        last_rd = '0;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_level", 32'(level), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_wr_en", 32'(sram_wr_en), 0);
        check("rst_rd_en", 32'(sram_rd_en), 0);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
    endtask

    // Driver + model step: drive one cycle of inputs, check against the word queue.
    task automatic step(input logic iv, input logic [DW-1:0] id, input logic ordy, input logic fl);
        logic [DW-1:0] head;
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
        last_push = 1'b0;
        if (fl) begin
            exp_q.delete();
            stalled = 1'b0;
        end else begin
            check("level", 32'(level), 32'(exp_q.size()));
            if (exp_q.size() < DEPTH) check("in_ready_open", 32'(in_ready), 1);
            if (exp_q.size() == DEPTH + 2) check("in_ready_full", 32'(in_ready), 0);
            check("wr_en", 32'(sram_wr_en), 32'(iv && in_ready));
            check("data_in", 32'(sram_data_in), 32'(id));
            if (stalled) begin
                check("stall_valid", 32'(out_valid), 1);
                check("stall_data", 32'(out_data), 32'(stall_data));
            end
            if (out_valid && ordy) begin
                check("pop_nonempty", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    head = exp_q.pop_front();
                    check("pop_data", 32'(out_data), 32'(head));
                end
                n_pop++;
            end
            if (iv && in_ready) begin
                exp_q.push_back(id);
                last_push = 1'b1;
                n_acc++;
            end
            if (sram_wr_en) begin
                if (last_wr == AW'(DEPTH - 1) && sram_wr_ptr == '0) wr_wrap = 1'b1;
                last_wr = sram_wr_ptr;
            end
            if (sram_rd_en) begin
                if (last_rd == AW'(DEPTH - 1) && sram_rd_ptr == '0) rd_wrap = 1'b1;
                last_rd = sram_rd_ptr;
            end
            stalled    = out_valid && !ordy;
            stall_data = out_data;
        end
    endtask

    initial begin
        logic [LW-1:0] prev_level;
        int            bias;
        int            budget;
        next_data = '0;

        // first-word latency
        do_reset();
        step(1'b1, 16'h0001, 1'b0, 1'b0);
        check("t1_wr_ptr", 32'(sram_wr_ptr), 0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("t1_rd_en", 32'(sram_rd_en), 1);
        check("t1_rd_ptr", 32'(sram_rd_ptr), 0);
        check("t1_valid_edge1", 32'(out_valid), 0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("t1_valid_inflight", 32'(out_valid), 0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("t1_valid_edge2", 32'(out_valid), 1);
        check("t1_data", 32'(out_data), 32'h0001);
        check("t1_level", 32'(level), 1);

        // fill to full with the consumer stalled
        do_reset();
        next_data = '0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            step(1'b1, next_data, 1'b0, 1'b0);
            if (last_push) next_data++;
        end
        check("fill_accepts", 32'(n_acc), DEPTH + 2);
        step(1'b1, next_data, 1'b0, 1'b0);
        check("fill_ready_low", 32'(in_ready), 0);
        check("fill_level", 32'(level), DEPTH + 2);
        check("fill_wr_wrap", 32'(wr_wrap), 1);

        // drain with continuous pushes across the pointer wrap
        prev_level = level;
        for (int i = 0; i < 300; i++) begin
            step(1'b1, next_data, 1'b1, 1'b0);
            if (last_push) next_data++;
            if (i >= 5) check("steady_level", 32'(level), 32'(prev_level));
            prev_level = level;
        end
        check("steady_rd_wrap", 32'(rd_wrap), 1);
        check("steady_pops", 32'(n_pop >= 300), 1);

        // randomized traffic with shifting consumer bias
        do_reset();
        bias = 50;
        for (int i = 0; i < 2000; i++) begin
            if (i % 250 == 0) bias = (bias == 15) ? 85 : 15;
            step(1'($urandom_range(0, 1)), 16'($urandom),
                 1'($urandom_range(0, 99) < bias), 1'b0);
        end
        budget = 0;
        while (level != '0 && budget < 400) begin
            step(1'b0, '0, 1'b1, 1'b0);
            budget++;
        end
        check("rand_drained", 32'(level), 0);
        check("rand_queue_empty", 32'(exp_q.size()), 0);

        // flush with a read in flight
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("fl_pop_issue", 32'(sram_rd_en), 1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("fl_level_pre", 32'(level), 5);
        step(1'b0, '0, 1'b0, 1'b0);
        check("fl_valid", 32'(out_valid), 0);
        check("fl_wr_ptr", 32'(sram_wr_ptr), 0);
        check("fl_rd_ptr", 32'(sram_rd_ptr), 0);
        step(1'b1, 16'habcd, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
        check("fl_new_valid", 32'(out_valid), 1);
        check("fl_new_data", 32'(out_data), 32'habcd);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("fl_no_ghost", 32'(out_valid), 0);

`ifdef FIFO_CTRL_ERR_FLAG_EN
        // overflow flag
        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        check("ovf_clear_before", 32'(err_ovf), 0);
        for (int i = 0; i < 3; i++) step(1'b1, 16'hdead, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("ovf_flag", 32'(err_ovf), 1);
        check("ovf_cnt", 32'(err_ovf_cnt), 3);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        check("ovf_flag_flushed", 32'(err_ovf), 0);
        check("ovf_cnt_flushed", 32'(err_ovf_cnt), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
